// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: March C- BIST engine for a byte-laned asynchronous SRAM.
// Runs {up(w0); up(r0,w1); up(r1,w0); dn(r0,w1); dn(r1,w0); up(r0)} over
// addresses 0..ADDR_LAST. Each op takes two cycles: SETUP, then STROBE.
// Optional feature macro: BIST_DIAG_EN (first-failure capture of address,
// element and read data). When it is undefined the diag outputs are tied 0.
module mem_bist_ctrl #(
  parameter int                ADDR_W    = 17,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_oe,
  output logic [1:0]        mem_cs,
  output logic [1:0]        mem_we,
  inout  wire  [DATA_W-1:0] mem_io
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t            state, nxt_state;
  logic [2:0]        elem, nxt_elem;
  logic              op_idx, nxt_op;
  logic [ADDR_W-1:0] addr, nxt_addr;
  logic              start_run;
  logic              err_flag;
  logic              rd_mismatch;
  logic              drive_en;
  logic [1:0]        nxt_cs, nxt_we;
  logic              nxt_oe, nxt_drive;

  // The second op of every two-op element is a write; element 0 is write-only.
  function automatic logic is_write(input logic [2:0] e, input logic o);
    return (e == 3'd0) || o;
  endfunction

  function automatic logic is_last_op(input logic [2:0] e, input logic o);
    return ((e == 3'd0) || (e == 3'd5)) ? 1'b1 : o;
  endfunction

  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic [DATA_W-1:0] write_bg(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  endfunction

  function automatic logic [DATA_W-1:0] read_bg(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  endfunction

  assign busy  = (state == SETUP) || (state == STROBE);
  assign done  = (state == DONE);
  assign pass  = done && !err_flag;
  assign mem_a = addr;

  // Write data follows the current element; it is only put on the bus while
  // drive_en is set, which never overlaps a cycle with mem_oe high.
  assign mem_io = drive_en ? write_bg(elem) : {DATA_W{1'bz}};

  // A read op is judged on the edge that ends its STROBE cycle.
  assign rd_mismatch = (state == STROBE) && !is_write(elem, op_idx) &&
                       (mem_io != read_bg(elem));

  // Next-state sequencing of element, op and address, plus the SRAM strobes
  // that the next cycle will need (registered below so they cannot glitch).
  always_comb begin
    nxt_state = state;
    nxt_elem  = elem;
    nxt_op    = op_idx;
    nxt_addr  = addr;
    start_run = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          nxt_state = SETUP;
          nxt_elem  = 3'd0;
          nxt_op    = 1'b0;
          nxt_addr  = '0;
          start_run = 1'b1;
        end
      end
      SETUP: nxt_state = STROBE;
      STROBE: begin
        nxt_state = SETUP;
        if (!is_last_op(elem, op_idx)) begin
          nxt_op = 1'b1;
        end else begin
          nxt_op = 1'b0;
          if (is_down(elem) ? (addr == '0) : (addr == ADDR_LAST)) begin
            if (elem == 3'd5) begin
              nxt_state = DONE;
            end else begin
              nxt_elem = elem + 3'd1;
              nxt_addr = is_down(elem + 3'd1) ? ADDR_LAST : '0;
            end
          end else begin
            nxt_addr = is_down(elem) ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
          end
        end
      end
      default: nxt_state = IDLE;
    endcase

    nxt_cs    = 2'b00;
    nxt_we    = 2'b00;
    nxt_oe    = 1'b0;
    nxt_drive = 1'b0;
    if ((nxt_state == SETUP) || (nxt_state == STROBE)) begin
      nxt_cs    = 2'b11;
      nxt_drive = is_write(nxt_elem, nxt_op);
      if (nxt_state == STROBE) begin
        nxt_we = is_write(nxt_elem, nxt_op) ? 2'b11 : 2'b00;
        nxt_oe = !is_write(nxt_elem, nxt_op);
      end
    end
  end

  // State, sequencing counters and registered SRAM control strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      elem     <= 3'd0;
      op_idx   <= 1'b0;
      addr     <= '0;
      mem_cs   <= 2'b00;
      mem_we   <= 2'b00;
      mem_oe   <= 1'b0;
      drive_en <= 1'b0;
    end else begin
      state    <= nxt_state;
      elem     <= nxt_elem;
      op_idx   <= nxt_op;
      addr     <= nxt_addr;
      mem_cs   <= nxt_cs;
      mem_we   <= nxt_we;
      mem_oe   <= nxt_oe;
      drive_en <= nxt_drive;
    end
  end

  // Sticky failure flag, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           err_flag <= 1'b0;
    else if (start_run)   err_flag <= 1'b0;
    else if (rd_mismatch) err_flag <= 1'b1;
  end

`ifdef BIST_DIAG_EN
  // Capture the first mismatch only; later ones leave the record untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_addr <= '0;
      fail_elem <= 3'd0;
      fail_data <= '0;
    end else if (start_run) begin
      fail_addr <= '0;
      fail_elem <= 3'd0;
      fail_data <= '0;
    end else if (rd_mismatch && !err_flag) begin
      fail_addr <= addr;
      fail_elem <= elem;
      fail_data <= mem_io;
    end
  end
`else
  assign fail_addr = '0;
  assign fail_elem = 3'd0;
  assign fail_data = '0;
`endif

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb_mem_bist_ctrl: self-checking bench for mem_bist_ctrl with an 8-word
// behavioural SRAM that can inject a single stuck-at bit on reads.
// Honours BIST_DIAG_EN the same way the design does.
module tb_mem_bist_ctrl;

  localparam int AW  = 17;
  localparam int DW  = 16;
  localparam int N   = 8;
  localparam int CYC = 20 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr, mem_a;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_data;
  logic          mem_oe;
  logic [1:0]    mem_cs, mem_we;
  wire  [DW-1:0] mem_io;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ADDR_LAST(17'd7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data),
    .mem_a(mem_a), .mem_oe(mem_oe), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_io(mem_io)
  );

  // Behavioural SRAM with a single optional stuck-at bit seen on reads.
  logic [DW-1:0] sram [N];
  bit            fault_en;
  int            fault_addr;
  logic [DW-1:0] fault_mask;
  bit            fault_sa1;
  logic [DW-1:0] rd_word;

  function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] v,
                                           input bit en, input int fa,
                                           input logic [DW-1:0] m, input bit sa1);
    if (en && a == fa) return sa1 ? (v | m) : (v & ~m);
    return v;
  endfunction

  always_comb rd_word = faulty(int'(mem_a[2:0]), sram[mem_a[2:0]],
                               fault_en, fault_addr, fault_mask, fault_sa1);

  assign mem_io = (mem_cs == 2'b11 && mem_oe) ? rd_word : {DW{1'bz}};

  always @(negedge clk)
    if (mem_cs == 2'b11 && mem_we == 2'b11) sram[mem_a[2:0]] <= mem_io;

  // Reference op list built straight from the March C- element definitions.
  typedef struct { int addr; bit wr; logic [DW-1:0] data; int elem; } op_t;
  op_t ops[$];

  typedef struct {
    bit f_en; int f_addr; int f_bit; bit f_sa1; int start_at;
    bit exp_pass; int exp_elem; int exp_addr; logic [DW-1:0] exp_data;
  } vec_t;

  function automatic void buildOps();
    // op codes: 0=w0 1=w1 2=r0 3=r1
    int nops [6] = '{1, 2, 2, 2, 2, 1};
    int code [6][2] = '{'{0,0}, '{2,1}, '{3,0}, '{2,1}, '{3,0}, '{2,0}};
    ops.delete();
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++)
        for (int o = 0; o < nops[e]; o++) begin
          op_t op;
          op.addr = (e == 3 || e == 4) ? (N - 1 - i) : i;
          op.wr   = (code[e][o] < 2);
          op.data = (code[e][o] == 1 || code[e][o] == 3) ? 16'hFFFF : 16'h0000;
          op.elem = e;
          ops.push_back(op);
        end
  endfunction

  // Plays the op list against an ideal memory plus the injected fault.
  function automatic vec_t modelRun(input vec_t v);
    logic [DW-1:0] m [N];
    logic [DW-1:0] val;
    bit seen = 0;
    vec_t r = v;
    r.exp_pass = 1; r.exp_elem = 0; r.exp_addr = 0; r.exp_data = '0;
    foreach (m[i]) m[i] = '0;
    foreach (ops[k]) begin
      if (ops[k].wr) m[ops[k].addr] = ops[k].data;
      else begin
        val = faulty(ops[k].addr, m[ops[k].addr], v.f_en, v.f_addr,
                     16'(1) << v.f_bit, v.f_sa1);
        if (val != ops[k].data && !seen) begin
          seen = 1; r.exp_pass = 0; r.exp_elem = ops[k].elem;
          r.exp_addr = ops[k].addr; r.exp_data = val;
        end
      end
    end
    return r;
  endfunction

  function automatic vec_t mkVec(bit en, int fa, int fb, bit sa1, int st,
                                 bit ep, int ee, int ea, logic [DW-1:0] ed);
    vec_t v;
    v.f_en = en; v.f_addr = fa; v.f_bit = fb; v.f_sa1 = sa1; v.start_at = st;
    v.exp_pass = ep; v.exp_elem = ee; v.exp_addr = ea; v.exp_data = ed;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkIdleBus(input string tag);
    checkOutput({tag, " mem_cs"}, 32'(mem_cs), 32'd0);
    checkOutput({tag, " mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, " mem_oe"}, 32'(mem_oe), 32'd0);
  endtask

  task automatic checkDiag(input string tag, input int ea, input int ee,
                           input logic [DW-1:0] ed);
`ifdef BIST_DIAG_EN
    checkOutput({tag, " fail_addr"}, 32'(fail_addr), 32'(ea));
    checkOutput({tag, " fail_elem"}, 32'(fail_elem), 32'(ee));
    checkOutput({tag, " fail_data"}, 32'(fail_data), 32'(ed));
`else
    checkOutput({tag, " fail_addr"}, 32'(fail_addr), 32'd0);
    checkOutput({tag, " fail_elem"}, 32'(fail_elem), 32'd0);
    checkOutput({tag, " fail_data"}, 32'(fail_data), 32'd0);
    if (ea + ee + int'(ed) < 0) $display("[TB] diag disabled");
`endif
  endtask

  // One full March run: start pulse, per-cycle bus checks, final status checks.
  task automatic applyStimulus(input vec_t v, input int idx);
    op_t op;
    bit  ph;
    fault_en = v.f_en; fault_addr = v.f_addr;
    fault_mask = 16'(1) << v.f_bit; fault_sa1 = v.f_sa1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checkOutput($sformatf("v%0d start busy", idx), 32'(busy), 32'd1);
    checkOutput($sformatf("v%0d start done", idx), 32'(done), 32'd0);
    checkOutput($sformatf("v%0d start pass", idx), 32'(pass), 32'd0);
    checkDiag($sformatf("v%0d start", idx), 0, 0, '0);
    for (int k = 0; k < CYC; k++) begin
      op = ops[k / 2];
      ph = k[0];
      checkOutput($sformatf("v%0d c%0d busy", idx, k), 32'(busy), 32'd1);
      checkOutput($sformatf("v%0d c%0d done", idx, k), 32'(done), 32'd0);
      checkOutput($sformatf("v%0d c%0d mem_a", idx, k), 32'(mem_a), 32'(op.addr));
      checkOutput($sformatf("v%0d c%0d mem_cs", idx, k), 32'(mem_cs), 32'd3);
      checkOutput($sformatf("v%0d c%0d mem_we", idx, k), 32'(mem_we),
                  (ph && op.wr) ? 32'd3 : 32'd0);
      checkOutput($sformatf("v%0d c%0d mem_oe", idx, k), 32'(mem_oe),
                  (ph && !op.wr) ? 32'd1 : 32'd0);
      if (op.wr)
        checkOutput($sformatf("v%0d c%0d wdata", idx, k), 32'(mem_io), 32'(op.data));
      start = (k == v.start_at);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput($sformatf("v%0d end done", idx), 32'(done), 32'd1);
    checkOutput($sformatf("v%0d end busy", idx), 32'(busy), 32'd0);
    checkOutput($sformatf("v%0d end pass", idx), 32'(pass), 32'(v.exp_pass));
    checkIdleBus($sformatf("v%0d end", idx));
    checkDiag($sformatf("v%0d end", idx), v.exp_addr, v.exp_elem, v.exp_data);
  endtask

  vec_t tbl[$];

  initial begin
    foreach (sram[i]) sram[i] = 16'($urandom);
    fault_en = 0; fault_addr = 0; fault_mask = '0; fault_sa1 = 0;
    buildOps();

    // Fixed scenarios with hand-derived expectations, then randomized faults.
    tbl.push_back(mkVec(0, 0, 0, 0, -1, 1, 0, 0, 16'h0000));
    tbl.push_back(mkVec(1, 5, 3, 0, -1, 0, 2, 5, 16'hFFF7));
    tbl.push_back(mkVec(0, 0, 0, 0, 30, 1, 0, 0, 16'h0000));
    tbl.push_back(mkVec(1, 0, 0, 1, -1, 0, 1, 0, 16'h0001));
    tbl.push_back(mkVec(1, 7, 15, 0, -1, 0, 2, 7, 16'h7FFF));
    for (int i = 0; i < 4; i++)
      tbl.push_back(modelRun(mkVec(1, int'($urandom_range(0, N - 1)),
                                   int'($urandom_range(0, DW - 1)),
                                   bit'($urandom_range(0, 1)), -1, 0, 0, 0, '0)));
    tbl.push_back(mkVec(0, 0, 0, 0, -1, 1, 0, 0, 16'h0000));

    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset pass", 32'(pass), 32'd0);
    checkOutput("reset mem_a", 32'(mem_a), 32'd0);
    checkIdleBus("reset");
    checkDiag("reset", 0, 0, '0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle busy", 32'(busy), 32'd0);

    foreach (tbl[i]) applyStimulus(tbl[i], i);

    // Abort mid-run with reset, then a clean full run must follow.
    fault_en = 1; fault_addr = 2; fault_mask = 16'h0100; fault_sa1 = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("pre-abort busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort pass", 32'(pass), 32'd0);
    checkOutput("abort mem_a", 32'(mem_a), 32'd0);
    checkIdleBus("abort");
    checkDiag("abort", 0, 0, '0);
    @(negedge clk) rst_n = 1'b1;
    applyStimulus(mkVec(0, 0, 0, 0, -1, 1, 0, 0, 16'h0000), 99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
